// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, control-transfer flushes,
// operand bypass selection and saturating stall/flush event counters.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 3,
    parameter int unsigned CTRL_LAT = 2,
    parameter bit          ZERO_HW  = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              use1_d,
    input  logic              use2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              regwrite_e,
    input  logic              memread_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    input  logic              taken_e,
    input  logic              cnt_clr,
    output logic              stallF_o,
    output logic              stallD_o,
    output logic              flushD_o,
    output logic              flushE_o,
    output logic [1:0]        bypA_sel_o,
    output logic [1:0]        bypB_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int unsigned MaxLat = (LOAD_LAT > CTRL_LAT) ? LOAD_LAT : CTRL_LAT;
    localparam int unsigned RemW   = $clog2(MaxLat) + 1;

    typedef enum logic [1:0] {StIdle, StLstall, StCflush} state_e;

    state_e           r_state, w_state_nxt;
    logic [RemW-1:0]  r_rem, w_rem_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_lu;
    logic             w_stallF, w_stallD, w_flushD, w_flushE;

    // Register 0 never matches when it is hardwired to zero.
    function automatic logic f_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && !(ZERO_HW && (a == '0));
    endfunction

    function automatic logic [1:0] f_byp(input logic [REG_AW-1:0] rs);
        if (regwrite_m && f_match(rd_m, rs)) begin
            return 2'd1;
        end else if (regwrite_w && f_match(rd_w, rs)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign w_lu = memread_e && regwrite_e &&
                  ((use1_d && f_match(rd_e, rs1_d)) || (use2_d && f_match(rd_e, rs2_d)));

    // Bypass selects: M-stage result beats W-stage data.
    always_comb begin
        bypA_sel_o = f_byp(rs1_e);
        bypB_sel_o = f_byp(rs2_e);
    end

    // Next-state and stall/flush decode.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stallF    = 1'b0;
        w_stallD    = 1'b0;
        w_flushD    = 1'b0;
        w_flushE    = 1'b0;
        // A taken transfer wins in IDLE and LSTALL, and restarts CFLUSH.
        if (taken_e) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
            if (CTRL_LAT > 1) begin
                w_state_nxt = StCflush;
                w_rem_nxt   = RemW'(CTRL_LAT - 1);
            end else begin
                w_state_nxt = StIdle;
                w_rem_nxt   = '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_lu) begin
                        w_stallF = 1'b1;
                        w_stallD = 1'b1;
                        w_flushE = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = StLstall;
                            w_rem_nxt   = RemW'(LOAD_LAT - 1);
                        end
                    end
                end
                StLstall: begin
                    w_stallF = 1'b1;
                    w_stallD = 1'b1;
                    w_flushE = 1'b1;
                    if (r_rem <= RemW'(1)) begin
                        w_state_nxt = StIdle;
                        w_rem_nxt   = '0;
                    end else begin
                        w_rem_nxt = r_rem - RemW'(1);
                    end
                end
                StCflush: begin
                    // lu ignored: the D instruction is being flushed anyway.
                    w_flushD = 1'b1;
                    if (r_rem <= RemW'(1)) begin
                        w_state_nxt = StIdle;
                        w_rem_nxt   = '0;
                    end else begin
                        w_rem_nxt = r_rem - RemW'(1);
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_rem_nxt   = '0;
                end
            endcase
        end
    end

    // Control outputs are held low for the whole reset pulse.
    assign stallF_o = w_stallF && !rst;
    assign stallD_o = w_stallD && !rst;
    assign flushD_o = w_flushD && !rst;
    assign flushE_o = w_flushE && !rst;

    // State and remaining-cycle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Saturating event counters; clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stallD_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((flushD_o || flushE_o) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: main instance with defaults and a
// second instance with register 0 hardwired to zero, sharing all inputs.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       use1_d, use2_d, regwrite_e, memread_e, regwrite_m, regwrite_w;
    logic       taken_e, cnt_clr;

    logic        stallF, stallD, flushD, flushE;
    logic [1:0]  bypA, bypB;
    logic [15:0] stall_cnt, flush_cnt;
    logic        z_stallF, z_stallD, z_flushD, z_flushE;
    logic [1:0]  z_bypA, z_bypB;
    logic [15:0] z_stall_cnt, z_flush_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use1_d(use1_d), .use2_d(use2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .taken_e(taken_e), .cnt_clr(cnt_clr),
        .stallF_o(stallF), .stallD_o(stallD), .flushD_o(flushD), .flushE_o(flushE),
        .bypA_sel_o(bypA), .bypB_sel_o(bypB),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    hazard_ctrl_unit #(.ZERO_HW(1'b1)) dut_z (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use1_d(use1_d), .use2_d(use2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .taken_e(taken_e), .cnt_clr(cnt_clr),
        .stallF_o(z_stallF), .stallD_o(z_stallD), .flushD_o(z_flushD), .flushE_o(z_flushE),
        .bypA_sel_o(z_bypA), .bypB_sel_o(z_bypB),
        .stall_cnt_o(z_stall_cnt), .flush_cnt_o(z_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic on, input logic [4:0] reg_n);
        memread_e  = on;
        regwrite_e = on;
        use1_d     = on;
        rd_e       = reg_n;
        rs1_d      = reg_n;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {use1_d, use2_d, regwrite_e, memread_e, regwrite_m, regwrite_w} = '0;
        taken_e = 1'b0;
        cnt_clr = 1'b0;
        step();
        step();
        // Reset: hazard and taken inputs must not leak to the outputs.
        set_load(1'b1, 5'd1);
        taken_e = 1'b1;
        #1;
        chk("rst_stallD", 32'(stallD), 0);
        chk("rst_flushD", 32'(flushD), 0);
        chk("rst_flushE", 32'(flushE), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        chk("rst_bypA", 32'(bypA), 0);
        taken_e = 1'b0;
        set_load(1'b0, 5'd0);
        step();
        rst = 1'b0;

        // Load-use on rs1: three stall cycles, then released.
        set_load(1'b1, 5'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("lu_stallF%0d", i), 32'(stallF), 1);
            chk($sformatf("lu_stallD%0d", i), 32'(stallD), 1);
            chk($sformatf("lu_flushE%0d", i), 32'(flushE), 1);
            chk($sformatf("lu_flushD%0d", i), 32'(flushD), 0);
            step();
        end
        set_load(1'b0, 5'd0);
        #1;
        chk("lu_end_stallD", 32'(stallD), 0);
        chk("lu_stall_cnt", 32'(stall_cnt), 3);
        chk("lu_flush_cnt", 32'(flush_cnt), 3);
        clear_cnt();
        chk("clr_stall_cnt", 32'(stall_cnt), 0);

        // Bypass priority and zero-register handling.
        rd_m = 5'd3; rd_w = 5'd3; regwrite_m = 1'b1; regwrite_w = 1'b1; rs1_e = 5'd3;
        #1 chk("byp_m", 32'(bypA), 1);
        regwrite_m = 1'b0;
        #1 chk("byp_w", 32'(bypA), 2);
        rs2_e = 5'd3;
        #1 chk("byp_b_w", 32'(bypB), 2);
        rs1_e = 5'd4;
        #1 chk("byp_none", 32'(bypA), 0);
        rd_m = 5'd0; regwrite_m = 1'b1; regwrite_w = 1'b0; rs1_e = 5'd0;
        #1 chk("byp_r0", 32'(bypA), 1);
        chk("byp_r0_zhw", 32'(z_bypA), 0);
        {rd_m, rd_w, rs1_e, rs2_e} = '0;
        {regwrite_m, regwrite_w} = '0;
        step();

        // Taken pulse: two flushD cycles, one flushE cycle.
        taken_e = 1'b1;
        #1;
        chk("tk_flushD0", 32'(flushD), 1);
        chk("tk_flushE0", 32'(flushE), 1);
        chk("tk_stallD0", 32'(stallD), 0);
        step();
        taken_e = 1'b0;
        #1;
        chk("tk_flushD1", 32'(flushD), 1);
        chk("tk_flushE1", 32'(flushE), 0);
        step();
        chk("tk_flushD2", 32'(flushD), 0);
        chk("tk_flush_cnt", 32'(flush_cnt), 2);
        chk("tk_stall_cnt", 32'(stall_cnt), 0);
        clear_cnt();

        // Taken during second stall cycle aborts the stall.
        set_load(1'b1, 5'd2);
        #1 chk("ab_stallD0", 32'(stallD), 1);
        step();
        taken_e = 1'b1;
        #1;
        chk("ab_stallD1", 32'(stallD), 0);
        chk("ab_flushD1", 32'(flushD), 1);
        chk("ab_flushE1", 32'(flushE), 1);
        step();
        taken_e = 1'b0;
        #1;
        chk("ab_cf_stallD", 32'(stallD), 0);
        chk("ab_cf_flushD", 32'(flushD), 1);
        step();
        set_load(1'b0, 5'd0);
        #1;
        chk("ab_end_flushD", 32'(flushD), 0);
        chk("ab_stall_cnt", 32'(stall_cnt), 1);
        chk("ab_flush_cnt", 32'(flush_cnt), 3);
        clear_cnt();

        // Register 0 load-use: stalls only without the hardwired zero.
        set_load(1'b1, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("r0_stallD%0d", i), 32'(stallD), 1);
            chk($sformatf("r0_zhw_stallD%0d", i), 32'(z_stallD), 0);
            step();
        end
        set_load(1'b0, 5'd0);
        #1;
        chk("r0_stall_cnt", 32'(stall_cnt), 3);
        chk("r0_zhw_stall_cnt", 32'(z_stall_cnt), 0);
        clear_cnt();

        // Asynchronous reset in the middle of a load stall.
        set_load(1'b1, 5'd1);
        step();
        #1 chk("mr_stallD_pre", 32'(stallD), 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_stallD", 32'(stallD), 0);
        chk("mr_flushE", 32'(flushE), 0);
        chk("mr_stall_cnt", 32'(stall_cnt), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mr_re_stallD%0d", i), 32'(stallD), 1);
            step();
        end
        set_load(1'b0, 5'd0);
        #1;
        chk("mr_end_stallD", 32'(stallD), 0);
        chk("mr_stall_cnt_after", 32'(stall_cnt), 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
